// File: rtl/cpu_sequencer_if.sv
// Control bus between the CPU sequencer and the datapath.
// The sequencer takes the slave side; the datapath or bench takes the master side.
`timescale 1ns/1ps
interface cpu_sequencer_if;
    logic        en;
    logic [1:0]  ins_byte;
    logic [1:0]  ins_mode;
    logic [1:0]  ins_ot;
    logic [3:0]  ins_opcode;
    logic        flag_eq;
    logic        flag_gt;
    logic        flag_lt;
    logic        ins_load;
    logic        ins2_load;
    logic        op1_load;
    logic        op2_load;
    logic        pc_inc;
    logic        pc_load;
    logic        ram_rd;
    logic        alu_en;
    logic        reg_load;
    logic        halted;
    logic        fault;
    logic [2:0]  state;
    logic [15:0] instr_count;

    modport slave (
        input  en, ins_byte, ins_mode, ins_ot, ins_opcode, flag_eq, flag_gt, flag_lt,
        output ins_load, ins2_load, op1_load, op2_load, pc_inc, pc_load, ram_rd,
               alu_en, reg_load, halted, fault, state, instr_count
    );

    modport master (
        output en, ins_byte, ins_mode, ins_ot, ins_opcode, flag_eq, flag_gt, flag_lt,
        input  ins_load, ins2_load, op1_load, op2_load, pc_inc, pc_load, ram_rd,
               alu_en, reg_load, halted, fault, state, instr_count
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback control FSM for the 16-bit CPU.
// Strobes decode directly from the current state and instruction fields.
`timescale 1ns/1ps
module cpu_sequencer #(
    parameter int unsigned RAM_WAIT    = 1,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic            clk,
    input  logic            rst,
    cpu_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        FETCH2    = 3'd3,
        MEMWAIT   = 3'd4,
        EXECUTE   = 3'd5,
        WRITEBACK = 3'd6,
        HALT      = 3'd7
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(RAM_WAIT - 1);

    state_t      state_q;
    logic [3:0]  wait_q;
    logic        halted_q;
    logic        fault_q;
    logic [15:0] count_q;

    logic illegal;
    logic halt_op;
    logic is_jump;
    logic jump_taken;

    always_comb begin
        // Direct addressing needs the second word, so a 1-word direct op is illegal.
        illegal = (bus.ins_ot == 2'b11) || (bus.ins_mode == 2'b11) ||
                  ((bus.ins_mode == 2'b10) && (bus.ins_byte != 2'd2));
        halt_op = (bus.ins_ot == 2'b00) && (bus.ins_opcode == HALT_OPCODE);
        is_jump = (bus.ins_ot == 2'b00) && (bus.ins_opcode[3:2] == 2'b10);
        case (bus.ins_opcode[1:0])
            2'b00:   jump_taken = 1'b1;
            2'b01:   jump_taken = bus.flag_eq;
            2'b10:   jump_taken = bus.flag_gt;
            default: jump_taken = bus.flag_lt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wait_q   <= '0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.en) state_q <= FETCH;
                FETCH: state_q <= DECODE;
                DECODE: begin
                    if (illegal) begin
                        state_q  <= HALT;
                        halted_q <= 1'b1;
                        fault_q  <= 1'b1;
                    end else if (halt_op) begin
                        state_q  <= HALT;
                        halted_q <= 1'b1;
                    end else if (bus.ins_byte == 2'd2) begin
                        state_q <= FETCH2;
                    end else begin
                        state_q <= EXECUTE;
                    end
                end
                FETCH2: begin
                    if (bus.ins_mode == 2'b10) begin
                        state_q <= MEMWAIT;
                        wait_q  <= '0;
                    end else begin
                        state_q <= EXECUTE;
                    end
                end
                MEMWAIT: begin
                    if (wait_q == WAIT_LAST) begin
                        state_q <= EXECUTE;
                        wait_q  <= '0;
                    end else begin
                        wait_q <= wait_q + 4'd1;
                    end
                end
                EXECUTE: begin
                    if (is_jump) begin
                        count_q <= count_q + 16'd1;
                        state_q <= bus.en ? FETCH : IDLE;
                    end else begin
                        state_q <= WRITEBACK;
                    end
                end
                WRITEBACK: begin
                    count_q <= count_q + 16'd1;
                    state_q <= bus.en ? FETCH : IDLE;
                end
                HALT: state_q <= HALT;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.ins_load  = 1'b0;
        bus.ins2_load = 1'b0;
        bus.op1_load  = 1'b0;
        bus.op2_load  = 1'b0;
        bus.pc_inc    = 1'b0;
        bus.pc_load   = 1'b0;
        bus.ram_rd    = 1'b0;
        bus.alu_en    = 1'b0;
        bus.reg_load  = 1'b0;
        case (state_q)
            FETCH: bus.ins_load = 1'b1;
            DECODE: begin
                if (!illegal && !halt_op) begin
                    bus.op1_load = 1'b1;
                    bus.op2_load = 1'b1;
                    bus.pc_inc   = 1'b1;
                end
            end
            FETCH2: begin
                bus.ins2_load = 1'b1;
                bus.pc_inc    = 1'b1;
            end
            MEMWAIT: bus.ram_rd = 1'b1;
            EXECUTE: begin
                bus.alu_en  = 1'b1;
                bus.pc_load = is_jump && jump_taken;
            end
            WRITEBACK: bus.reg_load = 1'b1;
            default: ;
        endcase
    end

    assign bus.halted      = halted_q;
    assign bus.fault       = fault_q;
    assign bus.state       = state_q;
    assign bus.instr_count = count_q;
endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer with RAM_WAIT=3: instruction flows, jumps,
// traps, reset priority and retired-count wrap.
`timescale 1ns/1ps
module tb_cpu_sequencer;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   pc_cnt;
    int   rd_cnt;
    int   wb_at;
    logic [8:0] f2_strb;

    cpu_sequencer_if bus();

    cpu_sequencer #(
        .RAM_WAIT   (3),
        .HALT_OPCODE(4'hF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {ins_load, ins2_load, op1_load, op2_load, pc_inc, pc_load, ram_rd, alu_en, reg_load}
    function automatic logic [8:0] strb();
        return {bus.ins_load, bus.ins2_load, bus.op1_load, bus.op2_load, bus.pc_inc,
                bus.pc_load, bus.ram_rd, bus.alu_en, bus.reg_load};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ins(input logic [1:0] b, input logic [1:0] m,
                           input logic [1:0] ot, input logic [3:0] op);
        bus.ins_byte   = b;
        bus.ins_mode   = m;
        bus.ins_ot     = ot;
        bus.ins_opcode = op;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.en = 1'b0;
        bus.flag_eq = 1'b0;
        bus.flag_gt = 1'b0;
        bus.flag_lt = 1'b0;
        set_ins(2'd1, 2'b00, 2'b00, 4'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("reset_state",  32'(bus.state), 32'd0);
        check("reset_halted", 32'(bus.halted), 32'd0);
        check("reset_fault",  32'(bus.fault), 32'd0);
        check("reset_count",  32'(bus.instr_count), 32'd0);
        check("reset_strb",   32'(strb()), 32'h000);

        // 1-word register ADD
        bus.en = 1'b1;
        set_ins(2'd1, 2'b00, 2'b01, 4'h0);
        step();
        check("add_fetch_state", 32'(bus.state), 32'd1);
        check("add_fetch_strb",  32'(strb()), 32'(9'b100000000));
        step();
        check("add_dec_state", 32'(bus.state), 32'd2);
        check("add_dec_strb",  32'(strb()), 32'(9'b001110000));
        step();
        check("add_exe_state", 32'(bus.state), 32'd5);
        check("add_exe_strb",  32'(strb()), 32'(9'b000000010));
        step();
        check("add_wb_state", 32'(bus.state), 32'd6);
        check("add_wb_strb",  32'(strb()), 32'(9'b000000001));
        step();
        check("add_next_state", 32'(bus.state), 32'd1);
        check("add_count",      32'(bus.instr_count), 32'd1);

        // 2-word direct op with three wait cycles, counted from FETCH entry
        set_ins(2'd2, 2'b10, 2'b01, 4'h0);
        pc_cnt = 0;
        rd_cnt = 0;
        wb_at = 0;
        f2_strb = '0;
        for (int k = 1; k <= 20; k++) begin
            if (bus.pc_inc) pc_cnt++;
            if (bus.ram_rd) rd_cnt++;
            if (bus.state == 3'd3) f2_strb = strb();
            if (bus.reg_load) begin
                wb_at = k;
                break;
            end
            step();
        end
        check("dir_wb_cycle", 32'(wb_at), 32'd8);
        check("dir_ram_rd",   32'(rd_cnt), 32'd3);
        check("dir_pc_inc",   32'(pc_cnt), 32'd2);
        check("dir_f2_strb",  32'(f2_strb), 32'(9'b010010000));
        step();
        check("dir_next_state", 32'(bus.state), 32'd1);
        check("dir_count",      32'(bus.instr_count), 32'd2);

        // JEQ taken
        set_ins(2'd1, 2'b00, 2'b00, 4'h9);
        bus.flag_eq = 1'b1;
        step();
        check("jeq_dec_strb", 32'(strb()), 32'(9'b001110000));
        step();
        check("jeq_exe_state", 32'(bus.state), 32'd5);
        check("jeq_t_strb",    32'(strb()), 32'(9'b000001010));
        step();
        check("jeq_t_next",  32'(bus.state), 32'd1);
        check("jeq_t_count", 32'(bus.instr_count), 32'd3);

        // JEQ not taken
        bus.flag_eq = 1'b0;
        step();
        step();
        check("jeq_n_strb", 32'(strb()), 32'(9'b000000010));
        step();
        check("jeq_n_next",  32'(bus.state), 32'd1);
        check("jeq_n_count", 32'(bus.instr_count), 32'd4);

        // JLT must look only at flag_lt
        set_ins(2'd1, 2'b00, 2'b00, 4'hB);
        bus.flag_eq = 1'b1;
        bus.flag_gt = 1'b1;
        bus.flag_lt = 1'b0;
        step();
        step();
        check("jlt_n_strb", 32'(strb()), 32'(9'b000000010));
        step();
        check("jlt_n_count", 32'(bus.instr_count), 32'd5);
        bus.flag_eq = 1'b0;
        bus.flag_gt = 1'b0;

        // en dropped during EXECUTE: writeback still happens, then IDLE
        set_ins(2'd1, 2'b00, 2'b01, 4'h1);
        step();
        step();
        check("endrop_exe_state", 32'(bus.state), 32'd5);
        bus.en = 1'b0;
        step();
        check("endrop_wb_strb", 32'(strb()), 32'(9'b000000001));
        step();
        check("endrop_idle", 32'(bus.state), 32'd0);
        check("endrop_count", 32'(bus.instr_count), 32'd6);
        step();
        check("endrop_stay_idle", 32'(bus.state), 32'd0);

        // reset in MEMWAIT
        bus.en = 1'b1;
        set_ins(2'd2, 2'b10, 2'b01, 4'h0);
        repeat (4) step();
        check("memrst_state", 32'(bus.state), 32'd4);
        check("memrst_ram_rd", 32'(bus.ram_rd), 32'd1);
        rst = 1'b1;
        bus.en = 1'b0;
        step();
        rst = 1'b0;
        check("memrst_idle", 32'(bus.state), 32'd0);
        check("memrst_strb", 32'(strb()), 32'h000);
        check("memrst_count", 32'(bus.instr_count), 32'd0);

        // illegal operation type traps to HALT with fault
        bus.en = 1'b1;
        set_ins(2'd1, 2'b00, 2'b11, 4'h0);
        step();
        step();
        check("ill_dec_strb", 32'(strb()), 32'h000);
        step();
        check("ill_state",  32'(bus.state), 32'd7);
        check("ill_halted", 32'(bus.halted), 32'd1);
        check("ill_fault",  32'(bus.fault), 32'd1);
        check("ill_strb",   32'(strb()), 32'h000);
        bus.en = 1'b0;
        step();
        bus.en = 1'b1;
        step();
        step();
        check("ill_en_toggle", 32'(bus.state), 32'd7);
        check("ill_count",     32'(bus.instr_count), 32'd0);
        rst = 1'b1;
        bus.en = 1'b0;
        step();
        rst = 1'b0;
        check("ill_rst_state",  32'(bus.state), 32'd0);
        check("ill_rst_fault",  32'(bus.fault), 32'd0);
        check("ill_rst_halted", 32'(bus.halted), 32'd0);

        // 1-word direct op is illegal
        bus.en = 1'b1;
        set_ins(2'd1, 2'b10, 2'b01, 4'h0);
        repeat (3) step();
        check("dir1_state", 32'(bus.state), 32'd7);
        check("dir1_fault", 32'(bus.fault), 32'd1);
        rst = 1'b1;
        bus.en = 1'b0;
        step();
        rst = 1'b0;

        // counter wrap: preset near the top while idle, then retire NOPs
        force dut.count_q = 16'hFFFD;
        #1;
        release dut.count_q;
        #1;
        check("wrap_preset", 32'(bus.instr_count), 32'hFFFD);
        set_ins(2'd1, 2'b00, 2'b00, 4'h0);
        bus.en = 1'b1;
        step();
        repeat (4) step();
        check("wrap_fffe", 32'(bus.instr_count), 32'hFFFE);
        repeat (4) step();
        check("wrap_ffff", 32'(bus.instr_count), 32'hFFFF);
        repeat (4) step();
        check("wrap_zero",  32'(bus.instr_count), 32'h0000);
        check("wrap_state", 32'(bus.state), 32'd1);

        // HALT opcode: clean halt, not counted
        set_ins(2'd1, 2'b00, 2'b00, 4'hF);
        step();
        check("halt_dec_strb", 32'(strb()), 32'h000);
        step();
        check("halt_state",  32'(bus.state), 32'd7);
        check("halt_halted", 32'(bus.halted), 32'd1);
        check("halt_fault",  32'(bus.fault), 32'd0);
        step();
        check("halt_count", 32'(bus.instr_count), 32'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
